// File: rtl/hsid_pkg.sv
// Shared widths, constants and the main sequencer state encoding for the HSI library search.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH     = 32;
    localparam int HSID_DATA_WIDTH     = 16;
    localparam int HSID_DATA_WIDTH_ACC = 48;
    localparam int HSID_BANDS_WIDTH    = 8;
    localparam int HSID_LIB_IDX_WIDTH  = 12;
    localparam int HSID_MAX_WORDS      = 128;

    localparam logic [HSID_DATA_WIDTH_ACC-1:0] HSID_MSE_INIT = '1;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_READ_MEASURE = 3'd1,
        ST_COMPUTE_MSE  = 3'd2,
        ST_WAIT_MSE     = 3'd3,
        ST_COMPARE_MSE  = 3'd4,
        ST_DONE         = 3'd5
    } hsid_main_state_t;

endpackage

// File: rtl/hsid_meas_buffer.sv
// Holds the measured pixel as packed band pairs; one write port, combinational read.
module hsid_meas_buffer #(
    parameter int WORD_WIDTH = 32,
    parameter int MAX_WORDS  = 128,
    parameter int ADDR_W     = $clog2(MAX_WORDS)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data
);

    // Contents are always rewritten before being read, so no reset is needed.
    logic [WORD_WIDTH-1:0] mem [MAX_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hsid_main_ctrl.sv
// Sequencer for the MSE library search: buffers the measured pixel, streams each library pixel
// into the MSE datapath, and tracks the smallest result and its index.
module hsid_main_ctrl
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH = HSID_WORD_WIDTH,
    parameter int DATA_WIDTH = HSID_DATA_WIDTH,
    parameter int ACC_WIDTH  = HSID_DATA_WIDTH_ACC,
    parameter int BANDS_W    = HSID_BANDS_WIDTH,
    parameter int LIB_W      = HSID_LIB_IDX_WIDTH,
    parameter int MAX_WORDS  = HSID_MAX_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BANDS_W-1:0]    hsp_bands,
    input  logic [LIB_W-1:0]      hsp_lib_size,
    input  logic                  meas_valid,
    output logic                  meas_ready,
    input  logic [WORD_WIDTH-1:0] meas_word,
    input  logic                  lib_valid,
    output logic                  lib_ready,
    input  logic [WORD_WIDTH-1:0] lib_word,
    output logic                  dp_clear,
    output logic                  dp_valid,
    output logic [WORD_WIDTH-1:0] dp_meas,
    output logic [WORD_WIDTH-1:0] dp_lib,
    output logic                  dp_last,
    input  logic                  dp_mse_valid,
    input  logic [ACC_WIDTH-1:0]  dp_mse,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [2:0]            state,
    output logic [ACC_WIDTH-1:0]  min_mse,
    output logic [LIB_W-1:0]      min_idx
);

    localparam int AW = $clog2(MAX_WORDS);

    hsid_main_state_t state_q, state_d;

    logic [BANDS_W-1:0]    bands_q;
    logic [LIB_W-1:0]      lib_size_q;
    logic [LIB_W-1:0]      idx_q;
    logic [BANDS_W-1:0]    wcnt_q;
    logic [ACC_WIDTH-1:0]  mse_q;
    logic [BANDS_W:0]      bands_inc;
    logic [BANDS_W-1:0]    n_words;
    logic                  last_word;
    logic                  trim_upper;
    logic                  zero_cfg;
    logic                  last_pixel;
    logic                  meas_hs;
    logic                  lib_hs;
    logic [WORD_WIDTH-1:0] buf_rd;

    // Two bands per word, rounded up for odd band counts.
    assign bands_inc  = {1'b0, bands_q} + {{BANDS_W{1'b0}}, 1'b1};
    assign n_words    = bands_inc[BANDS_W:1];
    assign last_word  = (wcnt_q == n_words - BANDS_W'(1));
    assign trim_upper = last_word && bands_q[0];
    assign zero_cfg   = (hsp_bands == '0) || (hsp_lib_size == '0);
    assign last_pixel = (idx_q == lib_size_q - LIB_W'(1));

    assign meas_ready = (state_q == ST_READ_MEASURE);
    assign lib_ready  = (state_q == ST_COMPUTE_MSE);
    assign meas_hs    = meas_valid && meas_ready;
    assign lib_hs     = lib_valid && lib_ready;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign state      = state_q;

    hsid_meas_buffer #(
        .WORD_WIDTH (WORD_WIDTH),
        .MAX_WORDS  (MAX_WORDS),
        .ADDR_W     (AW)
    ) u_meas_buffer (
        .clk     (clk),
        .wr_en   (meas_hs),
        .wr_addr (wcnt_q[AW-1:0]),
        .wr_data (meas_word),
        .rd_addr (wcnt_q[AW-1:0]),
        .rd_data (buf_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = zero_cfg ? ST_DONE : ST_READ_MEASURE;
                end
            end
            ST_READ_MEASURE: if (meas_hs && last_word) state_d = ST_COMPUTE_MSE;
            ST_COMPUTE_MSE:  if (lib_hs && last_word)  state_d = ST_WAIT_MSE;
            ST_WAIT_MSE:     if (dp_mse_valid)         state_d = ST_COMPARE_MSE;
            ST_COMPARE_MSE:  state_d = last_pixel ? ST_DONE : ST_COMPUTE_MSE;
            ST_DONE:         state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bands_q    <= '0;
            lib_size_q <= '0;
            idx_q      <= '0;
            wcnt_q     <= '0;
            mse_q      <= '0;
            dp_clear   <= 1'b0;
            dp_valid   <= 1'b0;
            dp_meas    <= '0;
            dp_lib     <= '0;
            dp_last    <= 1'b0;
            cfg_err    <= 1'b0;
            min_mse    <= ACC_WIDTH'(HSID_MSE_INIT);
            min_idx    <= '0;
        end else begin
            dp_clear <= 1'b0;
            dp_valid <= 1'b0;
            dp_last  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bands_q    <= hsp_bands;
                        lib_size_q <= hsp_lib_size;
                        wcnt_q     <= '0;
                        idx_q      <= '0;
                        cfg_err    <= zero_cfg;
                        min_mse    <= ACC_WIDTH'(HSID_MSE_INIT);
                        min_idx    <= '0;
                    end
                end
                ST_READ_MEASURE: begin
                    if (meas_hs) begin
                        wcnt_q <= last_word ? '0 : wcnt_q + BANDS_W'(1);
                        if (last_word) begin
                            idx_q    <= '0;
                            dp_clear <= 1'b1;
                        end
                    end
                end
                ST_COMPUTE_MSE: begin
                    if (lib_hs) begin
                        // The unused upper band of an odd-sized pixel contributes zero error.
                        dp_valid <= 1'b1;
                        dp_last  <= last_word;
                        dp_lib   <= trim_upper ? {{(WORD_WIDTH-DATA_WIDTH){1'b0}}, lib_word[DATA_WIDTH-1:0]}
                                               : lib_word;
                        dp_meas  <= trim_upper ? {{(WORD_WIDTH-DATA_WIDTH){1'b0}}, buf_rd[DATA_WIDTH-1:0]}
                                               : buf_rd;
                        wcnt_q   <= last_word ? '0 : wcnt_q + BANDS_W'(1);
                    end
                end
                ST_WAIT_MSE: begin
                    if (dp_mse_valid) begin
                        mse_q <= dp_mse;
                    end
                end
                ST_COMPARE_MSE: begin
                    // Strict compare keeps the earliest index on ties.
                    if (mse_q < min_mse) begin
                        min_mse <= mse_q;
                        min_idx <= idx_q;
                    end
                    if (!last_pixel) begin
                        idx_q    <= idx_q + LIB_W'(1);
                        wcnt_q   <= '0;
                        dp_clear <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
